// File: rtl/control_unit.sv
// control_unit: microprogrammed control sequencer for the 8-bit accumulator CPU.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous active-high reset
//   opcode         in   8   IR contents, sampled in DECODE
//   flag_zero      in   1   accumulator == 0, sampled in OPND_ADDR
//   mem_ready      in   1   memory finished the current read/write
//   control_signal out  32  registered micro-operation bus
//   halted         out  1   high while in HALT
//   illegal        out  1   sticky, set by an undefined opcode
//   mem_timeout    out  1   sticky, memory wait expired
//
// Optional feature: define CU_MEM_TIMEOUT_EN to bound memory waits to
// TIMEOUT_CYCLES cycles; otherwise waits are unbounded and mem_timeout is 0.
module control_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode,
    input  logic        flag_zero,
    input  logic        mem_ready,
    output logic [31:0] control_signal,
    output logic        halted,
    output logic        illegal,
    output logic        mem_timeout
);
    typedef enum logic [3:0] {
        FETCH_PC, FETCH_RD, FETCH_LAT, FETCH_IR, DECODE,
        OPND_PC, OPND_RD, OPND_LAT, OPND_ADDR,
        EXEC_RD, EXEC_LAT, EXEC_DO, ST_ACC, ST_WR, HALT
    } state_t;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_OR    = 8'h06;
    localparam logic [7:0] OP_JMP   = 8'h07;
    localparam logic [7:0] OP_JMPZ  = 8'h08;
    localparam logic [7:0] OP_NOT   = 8'h09;
    localparam logic [7:0] OP_SHR   = 8'h0A;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    state_t      r_state;
    state_t      w_next_raw;
    state_t      w_next;
    logic [7:0]  r_op;
    logic [31:0] r_cs;
    logic [31:0] w_cs;
    logic        r_halted;
    logic        r_illegal;
    logic        r_timeout;
    logic        w_wait_st;
    logic        w_tmo;
    logic        w_jump;
    logic        w_needs_opnd;
    logic        w_legal;

    assign w_wait_st    = (r_state == FETCH_RD) || (r_state == OPND_RD) ||
                          (r_state == EXEC_RD)  || (r_state == ST_WR);
    assign w_jump       = (r_op == OP_JMP) || (r_op == OP_JMPZ);
    assign w_needs_opnd = (opcode >= OP_LOAD) && (opcode <= OP_JMPZ);
    assign w_legal      = (opcode <= OP_SHR) || (opcode == OP_HALT);

`ifdef CU_MEM_TIMEOUT_EN
    logic [7:0] r_wait;
    // Counts cycles spent with mem_ready low; the current cycle is included.
    assign w_tmo = w_wait_st && !mem_ready &&
                   (({1'b0, r_wait} + 9'd1) >= 9'(TIMEOUT_CYCLES));
    always_ff @(posedge clk) begin
        if (rst)
            r_wait <= '0;
        else
            r_wait <= (w_next != r_state) ? '0 :
                      (w_wait_st && !mem_ready) ? r_wait + 8'd1 : r_wait;
    end
`else
    // Waits are unbounded; the limit only matters with the timeout build.
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_next_raw = r_state;
        case (r_state)
            FETCH_PC:  w_next_raw = FETCH_RD;
            FETCH_RD:  w_next_raw = mem_ready ? FETCH_LAT : FETCH_RD;
            FETCH_LAT: w_next_raw = FETCH_IR;
            FETCH_IR:  w_next_raw = DECODE;
            DECODE:    w_next_raw = (opcode == OP_HALT) ? HALT :
                                    w_needs_opnd ? OPND_PC : EXEC_DO;
            OPND_PC:   w_next_raw = OPND_RD;
            OPND_RD:   w_next_raw = mem_ready ? OPND_LAT : OPND_RD;
            OPND_LAT:  w_next_raw = OPND_ADDR;
            OPND_ADDR: w_next_raw = w_jump ? FETCH_PC :
                                    (r_op == OP_STORE) ? ST_ACC : EXEC_RD;
            EXEC_RD:   w_next_raw = mem_ready ? EXEC_LAT : EXEC_RD;
            EXEC_LAT:  w_next_raw = EXEC_DO;
            EXEC_DO:   w_next_raw = FETCH_PC;
            ST_ACC:    w_next_raw = ST_WR;
            ST_WR:     w_next_raw = mem_ready ? FETCH_PC : ST_WR;
            HALT:      w_next_raw = HALT;
            default:   w_next_raw = FETCH_PC;
        endcase
        w_next = w_tmo ? HALT : w_next_raw;
    end

    // Per-state micro-operations; registered below so the bus shows the
    // operation of the state occupied during the previous cycle.
    always_comb begin
        w_cs = '0;
        case (r_state)
            FETCH_PC, OPND_PC:         w_cs[2] = 1'b1;
            FETCH_RD, OPND_RD, EXEC_RD: w_cs[0] = 1'b1;
            FETCH_LAT, OPND_LAT: begin
                w_cs[4]  = 1'b1;
                w_cs[20] = 1'b1;
            end
            FETCH_IR:  w_cs[6] = 1'b1;
            OPND_ADDR: begin
                w_cs[7] = !w_jump;
                w_cs[3] = (r_op == OP_JMP) || ((r_op == OP_JMPZ) && flag_zero);
            end
            EXEC_LAT:  w_cs[4] = 1'b1;
            EXEC_DO: begin
                w_cs[8]  = (r_op == OP_LOAD);
                w_cs[10] = (r_op == OP_ADD);
                w_cs[11] = (r_op == OP_SUB);
                w_cs[12] = (r_op == OP_AND);
                w_cs[13] = (r_op == OP_OR);
                w_cs[14] = (r_op == OP_NOT);
                w_cs[15] = (r_op == OP_SHR);
            end
            ST_ACC:    w_cs[9] = 1'b1;
            ST_WR:     w_cs[5] = 1'b1;
            default:   w_cs = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH_PC;
            r_op      <= '0;
            r_cs      <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_op      <= (r_state == DECODE) ? opcode : r_op;
            r_cs      <= w_cs;
            r_halted  <= (r_state == HALT);
            r_illegal <= r_illegal || ((r_state == DECODE) && !w_legal);
            r_timeout <= r_timeout || w_tmo;
        end
    end

    assign control_signal = r_cs;
    assign halted         = r_halted;
    assign illegal        = r_illegal;
    assign mem_timeout    = r_timeout;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  opcode = 8'h00;
    logic        flag_zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] control_signal;
    logic        halted;
    logic        illegal;
    logic        mem_timeout;
    int          total = 0;
    int          bad = 0;
    logic [31:0] got [128];
    logic        got_h [128];
    logic        got_il [128];
    logic        got_to [128];

    always #5 clk = ~clk;

    control_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_zero(flag_zero),
        .mem_ready(mem_ready), .control_signal(control_signal),
        .halted(halted), .illegal(illegal), .mem_timeout(mem_timeout)
    );

    // Sample i is taken on the falling edge after rising edge i+1; low[i]
    // drops mem_ready for that rising edge.
    task automatic capture(input int n, input logic [127:0] low);
        for (int i = 0; i < n; i++) begin
            mem_ready = !low[i];
            @(negedge clk);
            got[i] = control_signal;
            got_h[i] = halted;
            got_il[i] = illegal;
            got_to[i] = mem_timeout;
        end
        mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 4;
        if (control_signal !== 32'h0) begin $display("FAIL reset_bus got=%h exp=0", control_signal); bad++; end
        if (halted !== 1'b0) begin $display("FAIL reset_halted got=%b exp=0", halted); bad++; end
        if (illegal !== 1'b0) begin $display("FAIL reset_illegal got=%b exp=0", illegal); bad++; end
        if (mem_timeout !== 1'b0) begin $display("FAIL reset_timeout got=%b exp=0", mem_timeout); bad++; end
        rst = 1'b0;
        capture(1, '0);
        total++;
        if (got[0] !== 32'h4) begin $display("FAIL reset_first_fetch got=%h exp=4", got[0]); bad++; end
    endtask

    task automatic test_nop();
        logic [31:0] e [7] = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h0, 32'h4};
        do_reset();
        opcode = 8'h00;
        capture(7, '0);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL nop_c%0d got=%h exp=%h", i + 1, got[i], e[i]); bad++; end
        end
        total++;
        if (got_il[6] !== 1'b0) begin $display("FAIL nop_illegal got=%b exp=0", got_il[6]); bad++; end
    endtask

    task automatic test_load_alu();
        logic [7:0] ops [5] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06};
        int bits [5] = '{8, 10, 11, 12, 13};
        logic [31:0] e [13];
        int inc;
        for (int k = 0; k < 5; k++) begin
            e = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h4, 32'h1, 32'h100010,
                  32'h80, 32'h1, 32'h10, 32'h0, 32'h4};
            e[11] = 32'h1 << bits[k];
            do_reset();
            opcode = ops[k];
            capture(13, '0);
            inc = 0;
            for (int i = 0; i < 13; i++) begin
                total++;
                if (got[i] !== e[i]) begin $display("FAIL alu_op%0h_c%0d got=%h exp=%h", ops[k], i + 1, got[i], e[i]); bad++; end
                inc += int'(got[i][20]);
            end
            total++;
            if (inc != 2) begin $display("FAIL alu_op%0h_pcinc got=%0d exp=2", ops[k], inc); bad++; end
        end
    endtask

    task automatic test_wait_load();
        logic [31:0] e [15] = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h4, 32'h1, 32'h1,
                               32'h100010, 32'h80, 32'h1, 32'h1, 32'h10, 32'h100, 32'h4};
        do_reset();
        opcode = 8'h01;
        capture(15, 128'h440);
        for (int i = 0; i < 15; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL wait_load_c%0d got=%h exp=%h", i + 1, got[i], e[i]); bad++; end
        end
    endtask

    task automatic test_fetch_wait();
        logic [31:0] e [9] = '{32'h4, 32'h1, 32'h1, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h0, 32'h4};
        do_reset();
        opcode = 8'h00;
        capture(9, 128'h6);
        for (int i = 0; i < 9; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL fetch_wait_c%0d got=%h exp=%h", i + 1, got[i], e[i]); bad++; end
        end
    endtask

    task automatic test_unary();
        logic [7:0] ops [2] = '{8'h09, 8'h0A};
        logic [31:0] ex [2] = '{32'h4000, 32'h8000};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = ops[k];
            capture(7, '0);
            total += 2;
            if (got[5] !== ex[k]) begin $display("FAIL unary_op%0h got=%h exp=%h", ops[k], got[5], ex[k]); bad++; end
            if (got[6] !== 32'h4) begin $display("FAIL unary_op%0h_next got=%h exp=4", ops[k], got[6]); bad++; end
        end
    endtask

    task automatic test_jmp();
        do_reset();
        opcode = 8'h07;
        flag_zero = 1'b0;
        capture(10, '0);
        total += 3;
        if (got[7] !== 32'h100010) begin $display("FAIL jmp_c8 got=%h exp=100010", got[7]); bad++; end
        if (got[8] !== 32'h8) begin $display("FAIL jmp_addr got=%h exp=8", got[8]); bad++; end
        if (got[9] !== 32'h4) begin $display("FAIL jmp_next got=%h exp=4", got[9]); bad++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1 [10] = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h4, 32'h1, 32'h100010, 32'h8, 32'h4};
        logic [31:0] e2 [9] = '{32'h1, 32'h100010, 32'h40, 32'h0, 32'h4, 32'h1, 32'h100010, 32'h0, 32'h4};
        do_reset();
        opcode = 8'h08;
        flag_zero = 1'b1;
        capture(10, '0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got[i] !== e1[i]) begin $display("FAIL jmpz_taken_c%0d got=%h exp=%h", i + 1, got[i], e1[i]); bad++; end
        end
        flag_zero = 1'b0;
        capture(9, '0);
        for (int i = 0; i < 9; i++) begin
            total++;
            if (got[i] !== e2[i]) begin $display("FAIL jmpz_not_c%0d got=%h exp=%h", i + 2, got[i], e2[i]); bad++; end
        end
    endtask

    task automatic test_store();
        logic [31:0] e [15] = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h4, 32'h1, 32'h100010,
                               32'h80, 32'h200, 32'h20, 32'h20, 32'h20, 32'h20, 32'h4};
        do_reset();
        opcode = 8'h02;
        capture(12, '0);
        total += 3;
        if (got[9] !== 32'h200) begin $display("FAIL store_acc got=%h exp=200", got[9]); bad++; end
        if (got[10] !== 32'h20) begin $display("FAIL store_wr got=%h exp=20", got[10]); bad++; end
        if (got[11] !== 32'h4) begin $display("FAIL store_next got=%h exp=4", got[11]); bad++; end
        do_reset();
        capture(15, 128'h1C00);
        for (int i = 0; i < 15; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL store_wait_c%0d got=%h exp=%h", i + 1, got[i], e[i]); bad++; end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] e [7] = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0, 32'h0, 32'h4};
        do_reset();
        opcode = 8'h3C;
        capture(7, '0);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL illegal_c%0d got=%h exp=%h", i + 1, got[i], e[i]); bad++; end
        end
        total += 2;
        if (got_il[3] !== 1'b0) begin $display("FAIL illegal_early got=%b exp=0", got_il[3]); bad++; end
        if (got_il[6] !== 1'b1) begin $display("FAIL illegal_set got=%b exp=1", got_il[6]); bad++; end
        opcode = 8'h00;
        capture(6, '0);
        total += 2;
        if (got_il[5] !== 1'b1) begin $display("FAIL illegal_sticky got=%b exp=1", got_il[5]); bad++; end
        if (got[5] !== 32'h4) begin $display("FAIL illegal_nop_next got=%h exp=4", got[5]); bad++; end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (illegal !== 1'b0) begin $display("FAIL illegal_rst got=%b exp=0", illegal); bad++; end
        rst = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] e [5] = '{32'h4, 32'h1, 32'h100010, 32'h40, 32'h0};
        do_reset();
        opcode = 8'hFF;
        capture(6, '0);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL halt_c%0d got=%h exp=%h", i + 1, got[i], e[i]); bad++; end
        end
        total += 3;
        if (got_h[4] !== 1'b0) begin $display("FAIL halt_early got=%b exp=0", got_h[4]); bad++; end
        if (got_h[5] !== 1'b1) begin $display("FAIL halt_set got=%b exp=1", got_h[5]); bad++; end
        if (got[5] !== 32'h0) begin $display("FAIL halt_bus got=%h exp=0", got[5]); bad++; end
        opcode = 8'h00;
        capture(20, 128'hF0F0);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (got[i] !== 32'h0 || got_h[i] !== 1'b1) begin
                $display("FAIL halt_hold_c%0d got=%h/%b exp=0/1", i, got[i], got_h[i]); bad++;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (halted !== 1'b0 || control_signal !== 32'h0) begin
            $display("FAIL halt_rst got=%h/%b exp=0/0", control_signal, halted); bad++;
        end
        rst = 1'b0;
        capture(1, '0);
        total++;
        if (got[0] !== 32'h4) begin $display("FAIL halt_restart got=%h exp=4", got[0]); bad++; end
    endtask

    task automatic test_rst_mid();
        do_reset();
        opcode = 8'h01;
        capture(10, 128'h200);
        total++;
        if (got[9] !== 32'h1) begin $display("FAIL mid_exec_rd got=%h exp=1", got[9]); bad++; end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (control_signal !== 32'h0) begin $display("FAIL mid_rst_bus got=%h exp=0", control_signal); bad++; end
        rst = 1'b0;
        capture(3, '0);
        total += 3;
        if (got[0] !== 32'h4) begin $display("FAIL mid_restart0 got=%h exp=4", got[0]); bad++; end
        if (got[1] !== 32'h1) begin $display("FAIL mid_restart1 got=%h exp=1", got[1]); bad++; end
        if (got[2] !== 32'h100010) begin $display("FAIL mid_restart2 got=%h exp=100010", got[2]); bad++; end
    endtask

    task automatic test_opcode_latch();
        logic [31:0] e [7] = '{32'h1, 32'h100010, 32'h80, 32'h1, 32'h10, 32'h100, 32'h4};
        do_reset();
        opcode = 8'h01;
        capture(6, '0);
        opcode = 8'h09;
        capture(7, '0);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== e[i]) begin $display("FAIL latch_c%0d got=%h exp=%h", i + 7, got[i], e[i]); bad++; end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = 8'h00;
`ifdef CU_MEM_TIMEOUT_EN
        capture(8, 128'hFF);
        for (int i = 1; i < 5; i++) begin
            total++;
            if (got[i] !== 32'h1) begin $display("FAIL tmo_wait_c%0d got=%h exp=1", i + 1, got[i]); bad++; end
        end
        total += 4;
        if (got_to[3] !== 1'b0) begin $display("FAIL tmo_early got=%b exp=0", got_to[3]); bad++; end
        if (got_to[4] !== 1'b1) begin $display("FAIL tmo_set got=%b exp=1", got_to[4]); bad++; end
        if (got[5] !== 32'h0) begin $display("FAIL tmo_bus got=%h exp=0", got[5]); bad++; end
        if (got_h[5] !== 1'b1) begin $display("FAIL tmo_halt got=%b exp=1", got_h[5]); bad++; end
`else
        capture(120, '1);
        for (int i = 1; i < 120; i++) begin
            total++;
            if (got[i] !== 32'h1 || got_to[i] !== 1'b0 || got_h[i] !== 1'b0) begin
                $display("FAIL no_tmo_c%0d got=%h/%b/%b exp=1/0/0", i + 1, got[i], got_to[i], got_h[i]); bad++;
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nop();
        test_load_alu();
        test_wait_load();
        test_fetch_wait();
        test_unary();
        test_jmp();
        test_back_to_back();
        test_store();
        test_illegal();
        test_halt();
        test_rst_mid();
        test_opcode_latch();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
